decoder3_8_pulse: RTL and testbench

DECODER3_8_PULSE -- requirements
Module: decoder3_8_pulse

---
 rtl/decoder3_8_pulse.sv | 106 ++++++++++
 tb/tb_decoder3_8_pulse.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/decoder3_8_pulse.sv
// 3-to-8 decoder that holds each decoded one-hot code for HOLD_CYCLES clocks.
// Define DECODER3_8_ACTIVE_LOW_EN for an active-low (74x138 style) out_onehot.
module decoder3_8_pulse #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    input  logic       in_en,
    output logic       in_ready,
    output logic [7:0] out_onehot,
    output logic       out_valid,
    output logic [3:0] drop_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

`ifdef DECODER3_8_ACTIVE_LOW_EN
    localparam logic [7:0] IDLE_PAT = 8'hFF;
`else
    localparam logic [7:0] IDLE_PAT = 8'h00;
`endif

    // The counter holds the remaining cycles after the current one, so it loads one less.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    function automatic logic [7:0] decode(input logic [2:0] code);
        decode = (8'h01 << code) ^ IDLE_PAT;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] onehot_q, onehot_d;
    logic       valid_q, valid_d;
    logic [3:0] drop_q, drop_d;
    logic       ready_s;

    assign ready_s    = (state_q == IDLE);
    assign in_ready   = ready_s;
    assign out_onehot = onehot_q;
    assign out_valid  = valid_q;
    assign drop_cnt   = drop_q;

    // Next-state, hold counter, output pattern and drop counter.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        drop_d   = drop_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_en) begin
                    state_d  = HOLD;
                    cnt_d    = HOLD_LOAD;
                    onehot_d = decode(in_code);
                    valid_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d  = IDLE;
                    onehot_d = IDLE_PAT;
                    valid_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = 8'd0;
                onehot_d = IDLE_PAT;
                valid_d  = 1'b0;
            end
        endcase
        if (in_valid && !ready_s && (drop_q != 4'd15)) begin
            drop_d = drop_q + 4'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            onehot_q <= IDLE_PAT;
            valid_q  <= 1'b0;
            drop_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_decoder3_8_pulse.sv
// Bench for decoder3_8_pulse: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances share stimulus
// and are compared every cycle against a remaining-cycles pulse model.
module tb_decoder3_8_pulse;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = 3'd0;
    logic       in_en = 1'b0;

    logic       rdy0, rdy1, vld0, vld1;
    logic [7:0] oh0, oh1;
    logic [3:0] drp0, drp1;

    int tests = 0;
    int fails = 0;

    int         m_left [2];
    logic [2:0] m_code [2];
    int         m_drop [2];

`ifdef DECODER3_8_ACTIVE_LOW_EN
    localparam logic [7:0] P_IDLE = 8'hFF;
    localparam logic [7:0] P02 = 8'hFD;
    localparam logic [7:0] P08 = 8'hF7;
    localparam logic [7:0] P20 = 8'hDF;
    localparam logic [7:0] P40 = 8'hBF;
    localparam logic [7:0] P80 = 8'h7F;
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] P_IDLE = 8'h00;
    localparam logic [7:0] P02 = 8'h02;
    localparam logic [7:0] P08 = 8'h08;
    localparam logic [7:0] P20 = 8'h20;
    localparam logic [7:0] P40 = 8'h40;
    localparam logic [7:0] P80 = 8'h80;
    localparam logic [7:0] INV = 8'h00;
`endif

    decoder3_8_pulse #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .in_en(in_en),
        .in_ready(rdy0), .out_onehot(oh0), .out_valid(vld0), .drop_cnt(drp0)
    );

    decoder3_8_pulse #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .in_en(in_en),
        .in_ready(rdy1), .out_onehot(oh1), .out_valid(vld1), .drop_cnt(drp1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_pat(input logic [2:0] c, input logic active);
        logic [7:0] p;
        p = active ? (8'h01 << c) : 8'h00;
        return p ^ INV;
    endfunction

    // Model: a pulse occupies the output for its hold length; offers while busy are drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_left[i] <= 0;
                m_code[i] <= 3'd0;
                m_drop[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_left[i] > 0) begin
                    m_left[i] <= m_left[i] - 1;
                    if (in_valid && m_drop[i] < 15) m_drop[i] <= m_drop[i] + 1;
                end else if (in_valid && in_en) begin
                    m_left[i] <= (i == 0) ? 4 : 1;
                    m_code[i] <= in_code;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("onehot_h4", oh0, exp_pat(m_code[0], m_left[0] > 0));
        check("valid_h4", vld0, m_left[0] > 0);
        check("ready_h4", rdy0, m_left[0] == 0);
        check("drop_h4", drp0, m_drop[0]);
        check("onehot_h1", oh1, exp_pat(m_code[1], m_left[1] > 0));
        check("valid_h1", vld1, m_left[1] > 0);
        check("ready_h1", rdy1, m_left[1] == 0);
        check("drop_h1", drp1, m_drop[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        int guard;
        repeat (3) tick();
        check("reset_onehot", oh0, P_IDLE);
        check("reset_drop", drp0, 0);
        check("reset_ready", rdy0, 1);
        rst_n = 1'b1;
        tick();

        // Single pulse of code 5
        in_valid = 1'b1; in_en = 1'b1; in_code = 3'd5;
        tick();
        in_valid = 1'b0;
        check("c5_first", oh0, P20);
        check("c5_ready_low", rdy0, 0);
        repeat (3) tick();
        check("c5_last", oh0, P20);
        check("c5_valid_last", vld0, 1);
        tick();
        check("c5_end", oh0, P_IDLE);
        check("c5_ready_back", rdy0, 1);

        // Disabled offer is consumed silently
        in_valid = 1'b1; in_en = 1'b0; in_code = 3'd2;
        repeat (3) tick();
        check("dis_onehot", oh0, P_IDLE);
        check("dis_ready", rdy0, 1);
        check("dis_drop", drp0, 0);
        in_valid = 1'b0;

        // Back-to-back sweep with in_valid held high
        in_en = 1'b1; in_valid = 1'b1; idx = 0; guard = 0;
        while (idx < 8 && guard < 200) begin
            in_code = idx[2:0];
            tick();
            guard++;
            if (m_left[0] == 4) begin
                if (idx == 7) check("sweep_c7", oh0, P80);
                idx++;
            end
        end
        check("sweep_done", idx, 8);
        in_valid = 1'b0;
        repeat (5) tick();
        check("sweep_drop_sat", drp0, 15);

        // HOLD_CYCLES=1: code 6 then code 1
        in_valid = 1'b1; in_code = 3'd6;
        tick();
        check("h1_c6", oh1, P40);
        in_code = 3'd1;
        tick();
        check("h1_gap", oh1, P_IDLE);
        tick();
        check("h1_c1", oh1, P02);
        in_valid = 1'b0;
        tick();
        check("h1_end", oh1, P_IDLE);
        repeat (6) tick();

        // Reset in the second hold cycle of a code-7 pulse
        in_valid = 1'b1; in_code = 3'd7;
        tick();
        in_valid = 1'b0;
        check("rst_c7", oh0, P80);
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("rst_onehot", oh0, P_IDLE);
        check("rst_valid", vld0, 0);
        check("rst_drop", drp0, 0);
        tick();
        rst_n = 1'b1;
        check("rel_ready", rdy0, 1);
        in_valid = 1'b1; in_code = 3'd3;
        tick();
        in_valid = 1'b0;
        check("rel_first", oh0, P08);
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
